// File: rtl/xif_copro_alu_if.sv
// xif_copro_alu_if: CV-X-IF issue/register/commit/result bundle between host (master) and coprocessor (slave).
interface xif_copro_alu_if #(
  parameter int X_ID_WIDTH     = 4,
  parameter int X_HARTID_WIDTH = 1,
  parameter int X_RFR_WIDTH    = 32
);
  logic                        issue_valid_i;
  logic                        issue_ready_o;
  logic [31:0]                 issue_instr_i;
  logic [X_HARTID_WIDTH-1:0]   issue_hartid_i;
  logic [X_ID_WIDTH-1:0]       issue_id_i;
  logic                        issue_accept_o;
  logic                        issue_writeback_o;
  logic [1:0]                  issue_register_read_o;
  logic                        issue_loadstore_o;
  logic                        register_valid_i;
  logic                        register_ready_o;
  logic [X_HARTID_WIDTH-1:0]   register_hartid_i;
  logic [X_ID_WIDTH-1:0]       register_id_i;
  logic [2*X_RFR_WIDTH-1:0]    register_rs_i;
  logic [1:0]                  register_rs_valid_i;
  logic                        commit_valid_i;
  logic [X_HARTID_WIDTH-1:0]   commit_hartid_i;
  logic [X_ID_WIDTH-1:0]       commit_id_i;
  logic                        commit_kill_i;
  logic                        result_valid_o;
  logic                        result_ready_i;
  logic [X_HARTID_WIDTH-1:0]   result_hartid_o;
  logic [X_ID_WIDTH-1:0]       result_id_o;
  logic [X_RFR_WIDTH-1:0]      result_data_o;
  logic [4:0]                  result_rd_o;
  logic                        result_we_o;
  logic                        result_exc_o;
  logic [5:0]                  result_exccode_o;
  logic                        result_dbg_o;
  logic                        result_err_o;
  modport master (
    output issue_valid_i, issue_instr_i, issue_hartid_i, issue_id_i,
    input  issue_ready_o, issue_accept_o, issue_writeback_o, issue_register_read_o, issue_loadstore_o,
    output register_valid_i, register_hartid_i, register_id_i, register_rs_i, register_rs_valid_i,
    input  register_ready_o,
    output commit_valid_i, commit_hartid_i, commit_id_i, commit_kill_i,
    input  result_valid_o, result_hartid_o, result_id_o, result_data_o, result_rd_o, result_we_o,
    input  result_exc_o, result_exccode_o, result_dbg_o, result_err_o,
    output result_ready_i
  );
  modport slave (
    input  issue_valid_i, issue_instr_i, issue_hartid_i, issue_id_i,
    output issue_ready_o, issue_accept_o, issue_writeback_o, issue_register_read_o, issue_loadstore_o,
    input  register_valid_i, register_hartid_i, register_id_i, register_rs_i, register_rs_valid_i,
    output register_ready_o,
    input  commit_valid_i, commit_hartid_i, commit_id_i, commit_kill_i,
    output result_valid_o, result_hartid_o, result_id_o, result_data_o, result_rd_o, result_we_o,
    output result_exc_o, result_exccode_o, result_dbg_o, result_err_o,
    input  result_ready_i
  );
endinterface

// File: rtl/xif_copro_alu.sv
// xif_copro_alu: CV-X-IF coprocessor with custom-0 ADD/SUB/XOR/MINU/MAXU,
// in-order queue that gathers operands and commit decisions before writing back.
module xif_copro_alu #(
  parameter int X_ID_WIDTH     = 4,
  parameter int X_HARTID_WIDTH = 1,
  parameter int X_RFR_WIDTH    = 32,
  parameter int DEPTH          = 4
) (
  input logic clk_i,
  input logic rst_i,
  xif_copro_alu_if.slave xif
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = X_HARTID_WIDTH + X_ID_WIDTH;
  localparam int W  = X_RFR_WIDTH;
  logic [DEPTH-1:0] v_q, ok_q, cm_q, kl_q, push_sel, reg_hit, cm_hit;
  logic [TW-1:0]    tag_q [DEPTH];
  logic [4:0]       rd_q  [DEPTH];
  logic [2:0]       op_q  [DEPTH];
  logic [W-1:0]     rs1_q [DEPTH];
  logic [W-1:0]     rs2_q [DEPTH];
  logic [AW-1:0]    head_q, tail_q;
  logic [AW:0]      cnt_q;
  logic             accept, push, pop, reg_wr, rv;
  logic [TW-1:0]    itag, rtag, ctag, htag;
  logic [W-1:0]     a, b, res;
  logic [2:0]       f3;
  assign f3     = xif.issue_instr_i[14:12];
  assign accept = xif.issue_instr_i[6:0] == 7'b0001011 && xif.issue_instr_i[31:25] == 7'd0 && f3 <= 3'd4;
  assign xif.issue_accept_o        = accept;
  assign xif.issue_writeback_o     = accept;
  assign xif.issue_register_read_o = accept ? 2'b11 : 2'b00;
  assign xif.issue_loadstore_o     = 1'b0;
  assign xif.issue_ready_o         = cnt_q < (AW+1)'(DEPTH);
  assign xif.register_ready_o      = 1'b1;
  assign itag   = {xif.issue_hartid_i, xif.issue_id_i};
  assign rtag   = {xif.register_hartid_i, xif.register_id_i};
  assign ctag   = {xif.commit_hartid_i, xif.commit_id_i};
  assign push   = xif.issue_valid_i && xif.issue_ready_o && accept;
  assign reg_wr = xif.register_valid_i && xif.register_rs_valid_i == 2'b11;
  // A tag match also covers the slot being filled this very cycle.
  always_comb begin
    push_sel = '0;
    reg_hit  = '0;
    cm_hit   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      push_sel[i] = push && tail_q == AW'(i);
      reg_hit[i]  = reg_wr && (v_q[i] || push_sel[i]) && (push_sel[i] ? itag : tag_q[i]) == rtag;
      cm_hit[i]   = xif.commit_valid_i && (v_q[i] || push_sel[i]) && (push_sel[i] ? itag : tag_q[i]) == ctag;
    end
  end
  assign rv   = v_q[head_q] && cm_q[head_q] && !kl_q[head_q] && ok_q[head_q];
  assign pop  = v_q[head_q] && (kl_q[head_q] || (rv && xif.result_ready_i));
  assign a    = rs1_q[head_q];
  assign b    = rs2_q[head_q];
  assign htag = tag_q[head_q];
  always_comb begin
    res = op_q[head_q] == 3'd0 ? a + b :
          op_q[head_q] == 3'd1 ? a - b :
          op_q[head_q] == 3'd2 ? a ^ b :
          op_q[head_q] == 3'd3 ? (a < b ? a : b) : (a > b ? a : b);
  end
  assign xif.result_valid_o   = rv;
  assign xif.result_hartid_o  = rv ? htag[TW-1:X_ID_WIDTH] : '0;
  assign xif.result_id_o      = rv ? htag[X_ID_WIDTH-1:0] : '0;
  assign xif.result_data_o    = rv ? res : '0;
  assign xif.result_rd_o      = rv ? rd_q[head_q] : 5'd0;
  assign xif.result_we_o      = rv;
  assign xif.result_exc_o     = 1'b0;
  assign xif.result_exccode_o = 6'd0;
  assign xif.result_dbg_o     = 1'b0;
  assign xif.result_err_o     = 1'b0;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v_q    <= '0;
      ok_q   <= '0;
      cm_q   <= '0;
      kl_q   <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push_sel[i]) begin
          v_q[i]  <= 1'b1;
          ok_q[i] <= 1'b0;
          cm_q[i] <= 1'b0;
          kl_q[i] <= 1'b0;
        end
        if (reg_hit[i]) ok_q[i] <= 1'b1;
        if (cm_hit[i]) begin
          cm_q[i] <= 1'b1;
          kl_q[i] <= xif.commit_kill_i;
        end
        if (pop && head_q == AW'(i)) v_q[i] <= 1'b0;
      end
      head_q <= head_q + AW'(pop);
      tail_q <= tail_q + AW'(push);
      cnt_q  <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  // Payload needs no reset: result fields are masked until an entry is fully ready.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push_sel[i]) begin
        tag_q[i] <= itag;
        rd_q[i]  <= xif.issue_instr_i[11:7];
        op_q[i]  <= f3;
      end
      if (reg_hit[i]) begin
        rs1_q[i] <= xif.register_rs_i[W-1:0];
        rs2_q[i] <= xif.register_rs_i[2*W-1:W];
      end
    end
  end
endmodule

// File: tb/tb_xif_copro_alu.sv
// tb_xif_copro_alu: scenario tasks drive the CV-X-IF; a scoreboard queue holds
// expected results in issue order and a monitor compares each delivered result.
module tb_xif_copro_alu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errs = 0;
  int   checks = 0;
  typedef struct { logic [3:0] id; logic [4:0] rd; logic [31:0] data; } exp_t;
  exp_t sb[$];
  xif_copro_alu_if xif ();
  xif_copro_alu dut (.clk_i(clk), .rst_i(rst), .xif(xif));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  always @(negedge clk) begin
    if (!rst && xif.result_valid_o && xif.result_ready_i) begin
      checks++;
      if (sb.size() == 0) begin
        errs++;
        $display("FAIL unexpected_result got id=%0d rd=%0d data=%h, none expected", xif.result_id_o, xif.result_rd_o, xif.result_data_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({xif.result_id_o, xif.result_rd_o, xif.result_data_o, xif.result_we_o, xif.result_hartid_o} !== {e.id, e.rd, e.data, 1'b1, 1'b0}) begin
          errs++;
          $display("FAIL result got id=%0d rd=%0d data=%h we=%0b exp id=%0d rd=%0d data=%h we=1",
                   xif.result_id_o, xif.result_rd_o, xif.result_data_o, xif.result_we_o, e.id, e.rd, e.data);
        end
      end
    end
  end
  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd);
    return {7'd0, 5'd2, 5'd1, f3, rd, 7'b0001011};
  endfunction
  task automatic do_issue(input logic [31:0] ins, input logic [3:0] id);
    xif.issue_valid_i = 1'b1;
    xif.issue_instr_i = ins;
    xif.issue_id_i    = id;
    @(posedge clk); #1;
    xif.issue_valid_i = 1'b0;
  endtask
  task automatic do_reg(input logic [3:0] id, input logic [31:0] rs1, input logic [31:0] rs2, input logic [1:0] vld);
    xif.register_valid_i    = 1'b1;
    xif.register_id_i       = id;
    xif.register_rs_i       = {rs2, rs1};
    xif.register_rs_valid_i = vld;
    @(posedge clk); #1;
    xif.register_valid_i = 1'b0;
  endtask
  task automatic do_commit(input logic [3:0] id, input logic kill);
    xif.commit_valid_i = 1'b1;
    xif.commit_id_i    = id;
    xif.commit_kill_i  = kill;
    @(posedge clk); #1;
    xif.commit_valid_i = 1'b0;
    xif.commit_kill_i  = 1'b0;
  endtask
  task automatic wait_drain(input string name);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin errs++; $display("FAIL %s_drain pending=%0d exp=0", name, sb.size()); end
  endtask
  task automatic test_reset;
    checks++; if (xif.issue_ready_o !== 1'b1) begin errs++; $display("FAIL reset_issue_ready got=%b exp=1", xif.issue_ready_o); end
    checks++; if (xif.register_ready_o !== 1'b1) begin errs++; $display("FAIL reset_register_ready got=%b exp=1", xif.register_ready_o); end
    checks++; if (xif.result_valid_o !== 1'b0) begin errs++; $display("FAIL reset_result_valid got=%b exp=0", xif.result_valid_o); end
    checks++; if ({xif.result_data_o, xif.result_id_o, xif.result_rd_o, xif.result_we_o} !== '0) begin errs++; $display("FAIL reset_result_fields got data=%h id=%0d rd=%0d exp=0", xif.result_data_o, xif.result_id_o, xif.result_rd_o); end
  endtask
  task automatic test_add;
    xif.issue_instr_i = mk(3'b000, 5'd10);
    xif.issue_id_i    = 4'd3;
    xif.issue_valid_i = 1'b1;
    #1;
    checks++; if (xif.issue_accept_o !== 1'b1) begin errs++; $display("FAIL add_accept got=%b exp=1", xif.issue_accept_o); end
    checks++; if (xif.issue_writeback_o !== 1'b1) begin errs++; $display("FAIL add_writeback got=%b exp=1", xif.issue_writeback_o); end
    checks++; if (xif.issue_register_read_o !== 2'b11) begin errs++; $display("FAIL add_regread got=%b exp=11", xif.issue_register_read_o); end
    checks++; if (xif.issue_loadstore_o !== 1'b0) begin errs++; $display("FAIL add_loadstore got=%b exp=0", xif.issue_loadstore_o); end
    @(posedge clk); #1;
    xif.issue_valid_i = 1'b0;
    do_reg(4'd3, 32'd5, 32'd7, 2'b11);
    checks++; if (xif.result_valid_o !== 1'b0) begin errs++; $display("FAIL add_precommit_valid got=%b exp=0", xif.result_valid_o); end
    sb.push_back('{4'd3, 5'd10, 32'd12});
    do_commit(4'd3, 1'b0);
    checks++; if (xif.result_valid_o !== 1'b1) begin errs++; $display("FAIL add_valid got=%b exp=1", xif.result_valid_o); end
    checks++; if ({xif.result_id_o, xif.result_rd_o, xif.result_data_o} !== {4'd3, 5'd10, 32'd12}) begin errs++; $display("FAIL add_fields got id=%0d rd=%0d data=%0d exp id=3 rd=10 data=12", xif.result_id_o, xif.result_rd_o, xif.result_data_o); end
    checks++; if ({xif.result_exc_o, xif.result_exccode_o, xif.result_dbg_o, xif.result_err_o} !== 9'd0) begin errs++; $display("FAIL add_exc got=%b exp=0", {xif.result_exc_o, xif.result_exccode_o, xif.result_dbg_o, xif.result_err_o}); end
    wait_drain("add");
  endtask
  task automatic test_reject;
    xif.issue_instr_i = {7'd0, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
    xif.issue_id_i    = 4'd1;
    xif.issue_valid_i = 1'b1;
    #1;
    checks++; if (xif.issue_accept_o !== 1'b0) begin errs++; $display("FAIL reject_accept got=%b exp=0", xif.issue_accept_o); end
    checks++; if (xif.issue_register_read_o !== 2'b00) begin errs++; $display("FAIL reject_regread got=%b exp=00", xif.issue_register_read_o); end
    @(posedge clk); #1;
    xif.issue_valid_i = 1'b0;
    xif.register_valid_i = 1'b1;
    xif.register_id_i = 4'd1;
    xif.register_rs_valid_i = 2'b11;
    #1;
    checks++; if (xif.register_ready_o !== 1'b1) begin errs++; $display("FAIL reject_reg_ready got=%b exp=1", xif.register_ready_o); end
    @(posedge clk); #1;
    xif.register_valid_i = 1'b0;
    do_commit(4'd1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    checks++; if (xif.result_valid_o !== 1'b0) begin errs++; $display("FAIL reject_no_result got=%b exp=0", xif.result_valid_o); end
  endtask
  task automatic test_kill;
    do_issue(mk(3'b010, 5'd5), 4'd1);
    do_issue(mk(3'b001, 5'd6), 4'd2);
    do_reg(4'd1, 32'd1, 32'd2, 2'b11);
    do_reg(4'd2, 32'd3, 32'd5, 2'b11);
    sb.push_back('{4'd2, 5'd6, 32'hFFFF_FFFE});
    do_commit(4'd1, 1'b1);
    do_commit(4'd2, 1'b0);
    wait_drain("kill");
  endtask
  task automatic test_partial_operands;
    do_issue(mk(3'b000, 5'd9), 4'd4);
    do_reg(4'd4, 32'd1, 32'd1, 2'b01);
    do_commit(4'd4, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (xif.result_valid_o !== 1'b0) begin errs++; $display("FAIL partial_ignored got=%b exp=0", xif.result_valid_o); end
    sb.push_back('{4'd4, 5'd9, 32'h30});
    do_reg(4'd4, 32'h10, 32'h20, 2'b11);
    checks++; if (xif.result_valid_o !== 1'b1) begin errs++; $display("FAIL partial_late_valid got=%b exp=1", xif.result_valid_o); end
    wait_drain("partial");
  endtask
  task automatic test_full_early_commit;
    xif.result_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      do_issue(mk(3'b100, 5'(k + 1)), 4'(8 + k));
      if (k == 2) begin
        checks++; if (xif.issue_ready_o !== 1'b1) begin errs++; $display("FAIL full_ready3 got=%b exp=1", xif.issue_ready_o); end
      end
    end
    checks++; if (xif.issue_ready_o !== 1'b0) begin errs++; $display("FAIL full_ready4 got=%b exp=0", xif.issue_ready_o); end
    for (int k = 0; k < 4; k++) do_commit(4'(8 + k), 1'b0);
    checks++; if (xif.result_valid_o !== 1'b0) begin errs++; $display("FAIL full_no_operands got=%b exp=0", xif.result_valid_o); end
    for (int k = 0; k < 4; k++) begin
      logic [31:0] r1;
      r1 = 32'(k * 10);
      sb.push_back('{4'(8 + k), 5'(k + 1), (r1 > 32'd25) ? r1 : 32'd25});
      do_reg(4'(8 + k), r1, 32'd25, 2'b11);
    end
    checks++; if ({xif.result_valid_o, xif.issue_ready_o} !== 2'b10) begin errs++; $display("FAIL full_pending got valid/ready=%b exp=10", {xif.result_valid_o, xif.issue_ready_o}); end
    xif.result_ready_i = 1'b1;
    @(posedge clk); #1;
    checks++; if (xif.issue_ready_o !== 1'b1) begin errs++; $display("FAIL full_ready_after_pop got=%b exp=1", xif.issue_ready_o); end
    wait_drain("full");
  endtask
  task automatic test_backpressure;
    xif.result_ready_i = 1'b0;
    do_issue(mk(3'b011, 5'd7), 4'd5);
    do_reg(4'd5, 32'd9, 32'd4, 2'b11);
    sb.push_back('{4'd5, 5'd7, 32'd4});
    do_commit(4'd5, 1'b0);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({xif.result_valid_o, xif.result_id_o, xif.result_rd_o, xif.result_data_o, xif.result_we_o} !== {1'b1, 4'd5, 5'd7, 32'd4, 1'b1}) begin
        errs++;
        $display("FAIL backpressure_c%0d got v=%b id=%0d rd=%0d data=%0d exp v=1 id=5 rd=7 data=4", c, xif.result_valid_o, xif.result_id_o, xif.result_rd_o, xif.result_data_o);
      end
      @(posedge clk); #1;
    end
    xif.result_ready_i = 1'b1;
    wait_drain("backpressure");
  endtask
  task automatic test_reset_mid;
    xif.result_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) do_issue(mk(3'b000, 5'd20), 4'(12 + k));
    for (int k = 0; k < 3; k++) do_reg(4'(12 + k), 32'd1, 32'd2, 2'b11);
    for (int k = 0; k < 3; k++) do_commit(4'(12 + k), 1'b0);
    checks++; if ({xif.result_valid_o, xif.issue_ready_o} !== 2'b10) begin errs++; $display("FAIL midrst_before got valid/ready=%b exp=10", {xif.result_valid_o, xif.issue_ready_o}); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (xif.result_valid_o !== 1'b0) begin errs++; $display("FAIL midrst_valid got=%b exp=0", xif.result_valid_o); end
    checks++; if (xif.issue_ready_o !== 1'b1) begin errs++; $display("FAIL midrst_ready got=%b exp=1", xif.issue_ready_o); end
    @(posedge clk); #1;
    rst = 1'b0;
    xif.result_ready_i = 1'b1;
    do_reg(4'd15, 32'd1, 32'd2, 2'b11);
    do_commit(4'd15, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    checks++; if (xif.result_valid_o !== 1'b0) begin errs++; $display("FAIL midrst_stale got=%b exp=0", xif.result_valid_o); end
  endtask
  initial begin
    xif.issue_valid_i = 1'b0; xif.issue_instr_i = '0; xif.issue_hartid_i = '0; xif.issue_id_i = '0;
    xif.register_valid_i = 1'b0; xif.register_hartid_i = '0; xif.register_id_i = '0;
    xif.register_rs_i = '0; xif.register_rs_valid_i = 2'b00;
    xif.commit_valid_i = 1'b0; xif.commit_hartid_i = '0; xif.commit_id_i = '0; xif.commit_kill_i = 1'b0;
    xif.result_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset;
    test_add;
    test_reject;
    test_kill;
    test_partial_operands;
    test_full_early_commit;
    test_backpressure;
    test_reset_mid;
    checks++;
    if (sb.size() != 0) begin errs++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
